alu_regfile_unit: RTL
=====================

// Module: alu_regfile_unit
// PURPOSE
//  Parametrised execute unit: register file (2 async read ports, 1 write port) and an
//  integrated ALU, sequenced by a 3-state FSM with a valid/ready instruction handshake.
//  Performs rd <- rs1 OP rs2 (or rd <- imm) with no testbench-side operand shuffling;
//  reports result + Z/C/V flags. Core of the next-gen single-issue datapath.
// PARAMETERS
//  WIDTH   32  datapath / register width, >= 4
//  NREGS    4  number of registers, power of 2, >= 2
//  AW      $clog2(NREGS)  register address width (localparam, derived)
//  SHW     $clog2(WIDTH)  shift amount width (localparam, derived)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      instruction present
//  in_ready  out  1      unit can accept (high only in IDLE)
//  in_op     in   3      opcode (see BEHAVIOUR)
//  in_rd     in   AW     destination register
//  in_rs1    in   AW     source 1
//  in_rs2    in   AW     source 2
//  in_imm    in   WIDTH  immediate, used by LDI only
//  done      out  1      1-cycle pulse: writeback performed this edge
//  result    out  WIDTH  value written, held until next done
//  flag_z    out  1      result == 0
//  flag_c    out  1      ADD: carry-out; SUB/SLT: 1 when rs1 >= rs2 unsigned; else 0
//  flag_v    out  1      signed overflow for ADD/SUB; else 0
//  dbg_addr  in   AW     debug read address
//  dbg_data  out  WIDTH  combinational rf[dbg_addr]
// BEHAVIOUR
//  Opcodes: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SLT (signed, result 0/1),
//   110 SHL (rs1 << rs2[SHW-1:0]), 111 LDI (result = in_imm). All arithmetic mod 2^WIDTH.
//  Reset: all registers = 0, state=IDLE, in_ready=1, done=0, result=0, flags=0.
//  FSM IDLE -> EXEC -> WB -> IDLE.
//   IDLE: in_ready=1; on in_valid at edge: capture op, rd, imm, rf[rs1], rf[rs2] -> EXEC.
//   EXEC: in_ready=0; at edge register ALU result + flags internally -> WB.
//   WB:   in_ready=0; at edge rf[rd] <= result, update result/flag outputs, done=1 -> IDLE.
//  Latency: accept at edge E0, done high in the cycle after edge E2; throughput 1 per 3 clk.
//  Operands read at accept edge, so back-to-back dependent instructions see prior writeback
//   (previous WB completes before next IDLE accept); no forwarding needed.
//  in_valid / in_* outside IDLE are ignored; the requester must hold them until accepted.
//  All registers writable, including R0; rd == rs1/rs2 is legal (old value used).
//  flag_* and result change only on the done edge; stable otherwise.
//  rst mid-operation (EXEC or WB): instruction aborted, no write, done stays 0, full reset.
//  rst dominates in_valid in the same cycle.
//  dbg_data reflects a write from the edge after done is asserted.
// STRUCTURE
//  Package alu_pkg: opcode localparams (OP_ADD..OP_LDI), FSM state encodings.
//  Sub-module alu_param #(WIDTH): combinational ALU (a, b, imm, op -> y, c, v), the
//   generalised successor of the fixed 32-bit ALU; FSM and register array live here.
// TESTING
//  1 LDI R1=9ABCDEF0, R2=FFFFFFFF, R3=00000001 -> dbg reads match; done 3 clk after accept each.
//  2 ADD R0=R1+R2 -> 9ABCDEEF, C=1 V=0; AND R1=R2&R3 -> 00000001, Z=0.
//  3 XOR R3=R2^R0 -> 65432110; SUB R2=R1-R3 -> 9ABCDEF1, C=0, V=0.
//  4 in_valid held high continuously -> in_ready low in EXEC/WB, exactly one accept per 3 clk.
//  5 LDI R0=5; ADD R1=R0+R0, rst asserted during EXEC -> no done, all dbg reads 0, in_ready=1.
//  6 WIDTH=8: LDI 7F, ADD 7F+01 -> 80, V=1; SLT 80<01 -> 01; SHL 01<<9 (amt 9 mod 8 =1) -> 02.

Source files
------------

// File: rtl/alu_regfile_unit_pkg.sv
// Shared opcodes and FSM encodings for the
// register-file execute unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile_unit_if.sv
// Instruction handshake, writeback report and
// debug read port of the execute unit.
interface alu_regfile_unit_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd,
    output in_rs1, in_rs2, in_imm,
    output dbg_addr,
    input  in_ready, done, result,
    input  flag_z, flag_c, flag_v,
    input  dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd,
    input  in_rs1, in_rs2, in_imm,
    input  dbg_addr,
    output in_ready, done, result,
    output flag_z, flag_c, flag_v,
    output dbg_data
  );

endinterface

// File: rtl/alu_regfile_unit_alu.sv
// Combinational ALU: result plus carry and
// signed-overflow for the selected opcode.
module alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_c,
  output logic             o_v
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic           w_ge;
  logic           w_lt;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};
  // no borrow out of the subtract means a >= b
  assign w_ge  = ~w_dif[WIDTH];
  assign w_lt  = $signed(i_a) < $signed(i_b);

  // opcode select for value and flags
  always_comb begin
    o_y = '0;
    o_c = 1'b0;
    o_v = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        o_y = w_sum[MSB:0];
        o_c = w_sum[WIDTH];
        o_v = (i_a[MSB] == i_b[MSB]) &&
              (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        o_y = w_dif[MSB:0];
        o_c = w_ge;
        o_v = (i_a[MSB] != i_b[MSB]) &&
              (w_dif[MSB] != i_a[MSB]);
      end
      OP_AND: o_y = i_a & i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_SLT: begin
        o_y = {{(WIDTH-1){1'b0}}, w_lt};
        o_c = w_ge;
      end
      OP_SHL: o_y = i_a << i_b[SHW-1:0];
      OP_LDI: o_y = i_imm;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile_unit.sv
// Execute unit: register file, operand capture,
// ALU stage and writeback, one instr per 3 clk.
module alu_regfile_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
) (
  input logic               clk,
  input logic               rst,
  alu_regfile_unit_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_accept;

  logic [WIDTH-1:0] r_rf [NREGS];

  logic [2:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_v;

  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_fc;
  logic             r_fv;
  logic             r_done;

  // next state and handshake decode
  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // operands are read at accept so a prior
  // writeback is already visible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= OP_ADD;
      r_rd  <= '0;
      r_imm <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_op  <= bus.in_op;
      r_rd  <= bus.in_rd;
      r_imm <= bus.in_imm;
      r_a   <= r_rf[bus.in_rs1];
      r_b   <= r_rf[bus.in_rs2];
    end
  end

  alu_param #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_imm (r_imm),
    .i_op  (r_op),
    .o_y   (w_y),
    .o_c   (w_c),
    .o_v   (w_v)
  );

  // ALU result held internally until writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_y <= w_y;
      r_c <= w_c;
      r_v <= w_v;
    end
  end

  // register write and visible result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_fc     <= 1'b0;
      r_fv     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_WB) begin
        r_rf[r_rd] <= r_y;
        r_result   <= r_y;
        r_z        <= (r_y == '0);
        r_fc       <= r_c;
        r_fv       <= r_v;
        r_done     <= 1'b1;
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.flag_z   = r_z;
  assign bus.flag_c   = r_fc;
  assign bus.flag_v   = r_fv;
  assign bus.dbg_data = r_rf[bus.dbg_addr];

endmodule
